cu_control_retime_pipe: RTL
===========================

Name: cu_control_retime_pipe

Overview:
- Parametrised successor to the compute-unit I/O register slice.
- Retimes NUM_CH valid/payload channels plus a done sideband through PIPE_DEPTH register stages.
- Provides a reset synchroniser, enable gating at ingress, and saturating per-channel drop counters.
- Reports pipeline-drained status so the control layer can sequence done/teardown safely.
- Sits between the AFU buffer layer and the graph-algorithm CU cluster control, in both directions, as two instances.

Parameters:
- NUM_CH, 8: number of independent valid/payload channels.
- PAYLOAD_W, 512: payload bits per channel.
- PIPE_DEPTH, 2: register stages, legal range 1..4.
- RSTN_SYNC_DEPTH, 2: reset-deassert synchroniser flops, minimum 1.
- CNT_W, 16: drop-counter width.

Ports:
- clock  in  1  clock.
- rstn_in  in  1  reset, asynchronous, active-low.
- enabled_in  in  1  ingress enable.
- clear_counts_in  in  1  synchronous clear of all drop counters.
- ch_valid_in  in  NUM_CH  per-channel valid.
- ch_payload_in  in  NUM_CH*PAYLOAD_W  channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- done_in  in  1  done sideband.
- ch_valid_out  out  NUM_CH  retimed valid.
- ch_payload_out  out  NUM_CH*PAYLOAD_W  retimed payload.
- done_out  out  1  retimed done.
- rstn_out  out  1  synchronised reset for downstream logic.
- enabled_out  out  1  registered enable.
- drained_out  out  1  no valid in any stage.
- drop_count_out  out  NUM_CH*CNT_W  per-channel dropped-beat counts.

Behaviour:
- Reset: the synchroniser chain is asserted asynchronously by rstn_in low, and deasserts RSTN_SYNC_DEPTH cycles after rstn_in rises. Its output is rstn_out and the internal reset for all other flops.
- Reset values:
  - ch_valid_out=0, ch_payload_out=0, done_out=0, enabled_out=0.
  - drained_out=1; all drop counters=0.
  - All internal stage valid, payload and done bits=0.
- Reset mid-operation: every in-flight beat and done bit is discarded immediately (asynchronous), with no partial output. Inputs are ignored until rstn_out is high.
- enabled_out: enabled_in registered once. Ingress gating uses enabled_out, not enabled_in, so a beat is gated by the enable value sampled the previous cycle.
- Ingress, stage 0: stage0.valid[i] <= ch_valid_in[i] & enabled_out.
- Payload registers load only when the incoming valid for that channel is 1, and otherwise hold. Payload beyond valid beats is don't-care but deterministic (holds the last accepted beat).
- Stages 1..PIPE_DEPTH-1 shift valid, payload and done unconditionally; there is no backpressure.
- Outputs are the last stage. Latency is PIPE_DEPTH cycles from input sample to output, for both valid and done.
- done travels as an extra bit through the same stages and is not gated by enable. It therefore can never overtake data accepted earlier.
- Drop counter i:
  - Increments when ch_valid_in[i] & ~enabled_out; saturates at 2^CNT_W-1.
  - clear_counts_in has priority but does not lose a same-cycle drop: clear plus drop in the same cycle gives 1; clear alone gives 0.
- drained_out is registered: 1 when no stage holds any valid bit and no done bit. It is updated each cycle from next-state stage contents, so it is coincident with the stages.
- Simultaneous enable falling with valid input: a beat sampled while enabled_out=1 passes through; a beat sampled the next cycle is dropped and counted.
- No combinational path from any input to any output.

Decomposition:
- Add to CU_PKG:
  - localparam limits for PIPE_DEPTH (1..4).
  - typedef retime_stage_t: valid vector, payload array, done bit.
- Sub-module cu_reset_sync (parameter DEPTH): asynchronous-assert, synchronous-deassert chain. It is reusable by the other cu_control variants.
- Drop counters are inline via a generate loop; a counter sub-module is not warranted.

Test Plan:
- Reset sync, RSTN_SYNC_DEPTH=2: release rstn_in → rstn_out rises exactly 2 cycles later; all outputs at reset values throughout.
- Latency, PIPE_DEPTH=3: enabled for ≥2 cycles, then ch_valid_in=8'h05 with payload 0xA5.. → ch_valid_out=8'h05 exactly 3 cycles later with matching payload; drained_out low during flight and high after.
- Enable drop: enabled_in=0 for 2 cycles, then ch_valid_in[3]=1 for 5 cycles → no output valid; drop_count_out[3]=5; other counters 0.
- Saturation and clear, CNT_W=4: 20 dropped beats on channel 0 → count 15; clear_counts_in with a simultaneous drop → count 1.
- Done ordering: valid beat on cycle t, done_in on t+1 → done_out one cycle after the valid output; done passes while enabled=0.
- Mid-flight reset: pulse rstn_in low with 2 beats in flight → ch_valid_out=0 immediately; no stale beat appears after rstn_out recovers.

Source files
------------

// File: rtl/cu_control_retime_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cu_control_retime_pipe_pkg
// Shared definitions for the cu_control retime slices: legal ranges for the
// pipeline depth and the reset-synchroniser depth.
// The retime_stage_t record depends on each instance's channel count and
// payload width, so it is declared inside the module that owns the stages.
// -----------------------------------------------------------------------------
package cu_control_retime_pipe_pkg;

  localparam int unsigned PIPE_DEPTH_MIN      = 1;
  localparam int unsigned PIPE_DEPTH_MAX      = 4;
  localparam int unsigned RSTN_SYNC_DEPTH_MIN = 1;

  function automatic bit pipe_depth_legal(input int unsigned depth);
    return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/cu_reset_sync.sv
// -----------------------------------------------------------------------------
// cu_reset_sync
// Reset synchroniser with asynchronous assertion and synchronous deassertion.
// rstn_out drops as soon as rstn_in drops, and rises DEPTH clock edges after
// rstn_in rises.
// Ports:
//   clock    : clock
//   rstn_in  : raw asynchronous active-low reset
//   rstn_out : synchronised active-low reset
// -----------------------------------------------------------------------------
module cu_reset_sync
  import cu_control_retime_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic rstn_in,
  output logic rstn_out
);

  logic [DEPTH-1:0] sync_q;

  // A one is shifted in from the bottom; the top bit is the released reset.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= DEPTH'({sync_q, 1'b1});
    end
  end

  assign rstn_out = sync_q[DEPTH-1];

  if (DEPTH < RSTN_SYNC_DEPTH_MIN) begin : g_depth_check
    $error("cu_reset_sync: DEPTH must be at least 1");
  end

endmodule

// File: rtl/cu_control_retime_pipe.sv
// -----------------------------------------------------------------------------
// cu_control_retime_pipe
// Retimes NUM_CH valid/payload channels plus a done sideband through
// PIPE_DEPTH register stages. Ingress is gated by the registered enable;
// beats offered while disabled are dropped and counted per channel with
// saturating counters. Also supplies a synchronised reset and a drained flag.
// Ports:
//   clock, rstn_in          : clock, asynchronous active-low reset
//   enabled_in              : ingress enable (registered to enabled_out)
//   clear_counts_in         : synchronous clear of all drop counters
//   ch_valid_in/payload_in  : per-channel valid and payload (ch i at i*PAYLOAD_W)
//   done_in                 : done sideband, never gated
//   ch_valid_out/payload_out, done_out : retimed outputs, PIPE_DEPTH latency
//   rstn_out                : synchronised reset for downstream logic
//   enabled_out             : registered enable
//   drained_out             : no valid or done bit held in any stage
//   drop_count_out          : per-channel dropped-beat counts (ch i at i*CNT_W)
// -----------------------------------------------------------------------------
module cu_control_retime_pipe
  import cu_control_retime_pipe_pkg::*;
#(
  parameter int unsigned NUM_CH          = 8,
  parameter int unsigned PAYLOAD_W       = 512,
  parameter int unsigned PIPE_DEPTH      = 2,
  parameter int unsigned RSTN_SYNC_DEPTH = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                          clock,
  input  logic                          rstn_in,
  input  logic                          enabled_in,
  input  logic                          clear_counts_in,
  input  logic [NUM_CH-1:0]             ch_valid_in,
  input  logic [NUM_CH*PAYLOAD_W-1:0]   ch_payload_in,
  input  logic                          done_in,
  output logic [NUM_CH-1:0]             ch_valid_out,
  output logic [NUM_CH*PAYLOAD_W-1:0]   ch_payload_out,
  output logic                          done_out,
  output logic                          rstn_out,
  output logic                          enabled_out,
  output logic                          drained_out,
  output logic [NUM_CH*CNT_W-1:0]       drop_count_out
);

  typedef struct packed {
    logic [NUM_CH-1:0]           vld;
    logic [NUM_CH*PAYLOAD_W-1:0] payload;
    logic                        done;
  } retime_stage_t;

  if (!pipe_depth_legal(PIPE_DEPTH)) begin : g_depth_check
    $error("cu_control_retime_pipe: PIPE_DEPTH must be within 1..4");
  end

  logic rst_n;

  cu_reset_sync #(
    .DEPTH (RSTN_SYNC_DEPTH)
  ) u_reset_sync (
    .clock    (clock),
    .rstn_in  (rstn_in),
    .rstn_out (rst_n)
  );

  assign rstn_out = rst_n;

  logic                enabled_q;
  logic [NUM_CH-1:0]   vld_acc;
  logic [NUM_CH-1:0]   drop;
  logic                busy_next;
  logic                drained_q;
  retime_stage_t       stage_p [PIPE_DEPTH];

  assign vld_acc = ch_valid_in & {NUM_CH{enabled_q}};
  assign drop    = ch_valid_in & ~{NUM_CH{enabled_q}};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      enabled_q <= 1'b0;
    end else begin
      enabled_q <= enabled_in;
    end
  end

  // Stage 0: gated ingress; payload only captured for accepted beats.
  // Stages 1..PIPE_DEPTH-1: unconditional shift, no backpressure.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        stage_p[k] <= '0;
      end
    end else begin
      stage_p[0].vld  <= vld_acc;
      stage_p[0].done <= done_in;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (vld_acc[i]) begin
          stage_p[0].payload[i*PAYLOAD_W +: PAYLOAD_W] <= ch_payload_in[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        stage_p[k] <= stage_p[k-1];
      end
    end
  end

  // Drained is computed from what the stages will hold after this edge,
  // so the flag lines up with the stage contents it describes.
  always_comb begin
    busy_next = (|vld_acc) | done_in;
    for (int k = 0; k < int'(PIPE_DEPTH) - 1; k++) begin
      busy_next = busy_next | (|stage_p[k].vld) | stage_p[k].done;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      drained_q <= 1'b1;
    end else begin
      drained_q <= ~busy_next;
    end
  end

  // Clear wins over the old count but keeps a drop seen in the same cycle.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_drop_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clear_counts_in) begin
        cnt_q <= CNT_W'(drop[i]);
      end else if (drop[i] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign drop_count_out[i*CNT_W +: CNT_W] = cnt_q;
  end

  assign ch_valid_out   = stage_p[PIPE_DEPTH-1].vld;
  assign ch_payload_out = stage_p[PIPE_DEPTH-1].payload;
  assign done_out       = stage_p[PIPE_DEPTH-1].done;
  assign enabled_out    = enabled_q;
  assign drained_out    = drained_q;

endmodule
